ddr_rd_pkt_engine: RTL and testbench



---
 rtl/ddr_rd_pkt_engine.sv | 193 +++++++++++++++++++
 tb/tb_ddr_rd_pkt_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_pkt_engine.sv
// rtl/ddr_rd_pkt_engine.sv - DDR read descriptor engine: AXI4 read bursts to one AXI-Stream packet
//
// Takes one read descriptor at a time (byte address, length in 64-bit words,
// last-word byte strobe). It splits the descriptor into AXI4 INCR read bursts.
// Each burst is limited by P_MAX_BURST and by 4 KB boundaries, and only one
// burst is outstanding at a time. The returned data goes out as a single
// AXI-Stream packet through a one-entry register slice.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_rd_ddr_addr/len/strb  descriptor: byte address, word count, last-word strobe (0 = all bytes)
//   i_rd_ddr_valid          descriptor valid, sampled only while o_rd_ddr_ready is high
//   o_rd_ddr_ready          engine idle and able to take a descriptor
//   o_rd_ddr_cpl            one-cycle pulse once the final word has left on the stream
//   o_rd_err                one-cycle pulse for each R beat whose rresp is non-zero
//   m_axi_ar*               AXI4 read address channel (INCR, 8-byte beats)
//   m_axi_r*                AXI4 read data channel
//   m_axis_t*               outgoing packet stream

module ddr_rd_pkt_engine #(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   P_BASE_ADDR        = '0,
  parameter int                              P_MAX_BURST        = 64,
  parameter int                              C_M_AXI_ID         = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_ddr_addr,
  input  logic [15:0]                   i_rd_ddr_len,
  input  logic [7:0]                    i_rd_ddr_strb,
  input  logic                          i_rd_ddr_valid,
  output logic                          o_rd_ddr_ready,
  output logic                          o_rd_ddr_cpl,
  output logic                          o_rd_err,
  output logic [3:0]                    m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [63:0]                   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [63:0]                   m_axis_tdata,
  output logic [7:0]                    m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_CPL} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;        // byte address of the current burst
  logic [15:0]     remaining;     // words still to be received for this descriptor
  logic [7:0]      strb_last;     // tkeep for the final word, already mapped 0 -> FF
  logic [8:0]      burst_beats;   // beat count of the burst in flight

  // Beat count for the next burst. It is the smallest of three limits:
  // the words remaining, the configured maximum, and the words left before
  // the next 4 KB boundary. The address is 8-byte aligned, so the boundary
  // term is exact.
  function automatic logic [8:0] calc_beats(input logic [11:0] a_lo, input logic [15:0] rem);
    logic [12:0] to_4k;
    logic [15:0] b;
    to_4k = (13'd4096 - {1'b0, a_lo}) >> 3;
    b = rem;
    if (b > 16'(P_MAX_BURST)) b = 16'(P_MAX_BURST);
    if (b > {3'b000, to_4k})  b = {3'b000, to_4k};
    return b[8:0];
  endfunction

  logic [AW-1:0] accept_addr;
  logic [8:0]    first_beats;
  logic [AW-1:0] next_addr;
  logic [15:0]   next_rem;
  logic [8:0]    next_beats;
  logic          r_hs;
  logic          t_hs;

  assign accept_addr = i_rd_ddr_addr + P_BASE_ADDR;
  assign first_beats = calc_beats(accept_addr[11:0], i_rd_ddr_len);
  assign next_addr   = addr_q + AW'({burst_beats, 3'b000});
  assign next_rem    = remaining - 16'd1;
  assign next_beats  = calc_beats(next_addr[11:0], next_rem);

  assign m_axi_arid    = 4'(C_M_AXI_ID);
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;

  // The slice accepts a new word when it is empty or is being emptied this cycle.
  assign m_axi_rready = (state == S_DATA) && (!m_axis_tvalid || m_axis_tready);
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign t_hs         = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      remaining      <= '0;
      strb_last      <= '0;
      burst_beats    <= '0;
      o_rd_ddr_ready <= 1'b0;
      o_rd_ddr_cpl   <= 1'b0;
      o_rd_err       <= 1'b0;
      m_axi_arvalid  <= 1'b0;
      m_axi_araddr   <= '0;
      m_axi_arlen    <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tlast   <= 1'b0;
    end else begin
      o_rd_ddr_cpl <= 1'b0;
      o_rd_err     <= r_hs && (m_axi_rresp != 2'b00);

      // Drain the slice. A load in S_DATA below takes precedence.
      if (t_hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          o_rd_ddr_ready <= 1'b1;
          if (i_rd_ddr_valid && o_rd_ddr_ready) begin
            o_rd_ddr_ready <= 1'b0;
            addr_q         <= accept_addr;
            remaining      <= i_rd_ddr_len;
            strb_last      <= (i_rd_ddr_strb == 8'h00) ? 8'hFF : i_rd_ddr_strb;
            if (i_rd_ddr_len == 16'd0) begin
              state <= S_CPL;
            end else begin
              burst_beats   <= first_beats;
              m_axi_araddr  <= accept_addr;
              m_axi_arlen   <= 8'(first_beats - 9'd1);
              m_axi_arvalid <= 1'b1;
              state         <= S_AR;
            end
          end
        end

        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= S_DATA;
          end
        end

        S_DATA: begin
          if (r_hs) begin
            // The word count alone decides which word is last. rlast only ends the burst.
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= m_axi_rdata;
            m_axis_tlast  <= (remaining == 16'd1);
            m_axis_tkeep  <= (remaining == 16'd1) ? strb_last : 8'hFF;
            remaining     <= next_rem;
            if (m_axi_rlast) begin
              addr_q <= next_addr;
              if (remaining != 16'd1) begin
                burst_beats   <= next_beats;
                m_axi_araddr  <= next_addr;
                m_axi_arlen   <= 8'(next_beats - 9'd1);
                m_axi_arvalid <= 1'b1;
                state         <= S_AR;
              end else begin
                state <= S_CPL;
              end
            end
          end
        end

        S_CPL: begin
          // Complete once the final word has left the slice.
          // The next descriptor can be taken in the same cycle.
          if (!m_axis_tvalid || m_axis_tready) begin
            o_rd_ddr_cpl   <= 1'b1;
            o_rd_ddr_ready <= 1'b1;
            state          <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_pkt_engine.sv
// tb/tb_ddr_rd_pkt_engine.sv - directed self-checking bench for ddr_rd_pkt_engine

module tb_ddr_rd_pkt_engine;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d_addr = '0;
  logic [15:0] d_len = '0;
  logic [7:0]  d_strb = '0;
  logic        d_valid = 1'b0;
  logic        ready, cpl, err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;

  ddr_rd_pkt_engine #(
    .C_M_AXI_ADDR_WIDTH(32),
    .P_BASE_ADDR(BASE),
    .P_MAX_BURST(64),
    .C_M_AXI_ID(0)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_ddr_addr(d_addr), .i_rd_ddr_len(d_len), .i_rd_ddr_strb(d_strb),
    .i_rd_ddr_valid(d_valid), .o_rd_ddr_ready(ready), .o_rd_ddr_cpl(cpl), .o_rd_err(err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, cleared per test.
  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];
  logic [31:0] q_araddr[$];
  logic [7:0]  q_arlen[$];
  int n_cpl, n_err, cpl_cyc, last_t_cyc, first_ar_cyc, first_arhs_cyc;
  int rr_viol, ar_viol, cpl_no_ready;

  // AXI slave configuration and state.
  int          ar_delay = 0;
  bit          tready_toggle = 1'b0;
  int          err_beat = -1;
  int          r_beat_idx = 0;
  bit          bur_active = 1'b0;
  logic [31:0] bur_addr = '0;
  int          bur_left = 0;
  int          ar_wait = 0;

  task automatic clear_log();
    q_data.delete(); q_keep.delete(); q_last.delete();
    q_araddr.delete(); q_arlen.delete();
    n_cpl = 0; n_err = 0; cpl_cyc = -1; last_t_cyc = -1;
    first_ar_cyc = -1; first_arhs_cyc = -1;
    rr_viol = 0; ar_viol = 0; cpl_no_ready = 0; r_beat_idx = 0;
  endtask

  // Monitor plus slave: observe at the falling edge, drive 1 time unit after the rising edge.
  initial begin
    logic ar_f, r_f, prev_stall;
    logic [31:0] s_araddr, p_araddr;
    logic [7:0]  s_arlen, p_arlen;
    ar_f = 0; r_f = 0; prev_stall = 0;
    s_araddr = '0; s_arlen = '0; p_araddr = '0; p_arlen = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; tready = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ar_f = arvalid && arready;
        r_f  = rvalid && rready;
        s_araddr = araddr; s_arlen = arlen;
        if (arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
        if (prev_stall && (!arvalid || araddr !== p_araddr || arlen !== p_arlen)) ar_viol++;
        prev_stall = arvalid && !arready; p_araddr = araddr; p_arlen = arlen;
        if (tvalid && !tready && rready) rr_viol++;
        if (ar_f) begin
          q_araddr.push_back(araddr); q_arlen.push_back(arlen);
          if (first_arhs_cyc < 0) first_arhs_cyc = cyc;
        end
        if (tvalid && tready) begin
          q_data.push_back(tdata); q_keep.push_back(tkeep); q_last.push_back(tlast);
          if (tlast) last_t_cyc = cyc;
        end
        if (cpl) begin
          n_cpl++; cpl_cyc = cyc;
          if (!ready) cpl_no_ready++;
        end
        if (err) n_err++;
      end else begin
        ar_f = 0; r_f = 0; prev_stall = 0;
      end
      @(posedge clk); #1;
      if (rst) begin
        bur_active = 0; arready = 0; rvalid = 0; rlast = 0; ar_wait = 0;
      end else begin
        if (r_f) begin
          bur_addr = bur_addr + 32'd8; bur_left--; r_beat_idx++;
          if (bur_left == 0) bur_active = 0;
        end
        if (ar_f) begin
          bur_active = 1; bur_addr = s_araddr; bur_left = int'(s_arlen) + 1;
        end
        if (arvalid && !bur_active) begin
          if (ar_wait >= ar_delay) arready = 1;
          else begin arready = 0; ar_wait++; end
        end else begin
          arready = 0; ar_wait = 0;
        end
        rvalid = bur_active;
        rdata  = {32'h0, bur_addr};
        rlast  = (bur_left == 1);
        rresp  = (r_beat_idx == err_beat) ? 2'b10 : 2'b00;
        tready = tready_toggle ? ~tready : 1'b1;
      end
    end
  end

  task automatic send_desc(input logic [31:0] a, input logic [15:0] l, input logic [7:0] s,
                           output int acc);
    bit ok;
    ok = 0; acc = -1;
    @(posedge clk); #2;
    d_addr = a; d_len = l; d_strb = s; d_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1; acc = cyc; end
    end
    @(posedge clk); #2;
    d_valid = 0;
    if (!ok) check("desc_accept_timeout", 0, 1);
  endtask

  task automatic wait_cpl(input int n);
    int i;
    i = 0;
    while (n_cpl < n && i < 3000) begin @(posedge clk); i++; end
    if (n_cpl < n) check("cpl_timeout", 64'(n_cpl), 64'(n));
    repeat (3) @(posedge clk);
  endtask

  task automatic check_pkt(input string t, input logic [31:0] a, input int len, input logic [7:0] s);
    int bad_d, bad_k, n_last;
    logic [7:0] lk;
    bad_d = 0; bad_k = 0; n_last = 0;
    lk = (s == 8'h00) ? 8'hFF : s;
    check({t, "_nbeats"}, 64'(q_data.size()), 64'(len));
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== {32'h0, BASE + a + 32'(i * 8)}) bad_d++;
      if (q_keep[i] !== ((i == len - 1) ? lk : 8'hFF)) bad_k++;
      if (q_last[i]) n_last++;
    end
    check({t, "_data_bad"}, 64'(bad_d), 0);
    check({t, "_keep_bad"}, 64'(bad_k), 0);
    check({t, "_ntlast"}, 64'(n_last), 1);
    if (q_data.size() > 0) check({t, "_tlast_end"}, 64'(q_last[q_data.size()-1]), 1);
    check({t, "_ncpl"}, 64'(n_cpl), 1);
    check({t, "_cpl_timing"}, 64'(cpl_cyc), 64'(last_t_cyc + 1));
    check({t, "_cpl_ready"}, 64'(cpl_no_ready), 0);
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_ready"}, 64'(ready), 0);
    check({t, "_cpl"}, 64'(cpl), 0);
    check({t, "_err"}, 64'(err), 0);
    check({t, "_arvalid"}, 64'(arvalid), 0);
    check({t, "_rready"}, 64'(rready), 0);
    check({t, "_tvalid"}, 64'(tvalid), 0);
    check({t, "_tlast"}, 64'(tlast), 0);
    check({t, "_araddr"}, 64'(araddr), 0);
    check({t, "_arlen"}, 64'(arlen), 0);
    check({t, "_tdata"}, tdata, 0);
    check({t, "_tkeep"}, 64'(tkeep), 0);
  endtask

  initial begin
    int acc, i, n_last_part;
    clear_log();

    // Reset state and ready rising one clock after release.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #2 rst = 0;
    @(negedge clk); check("rst0_ready_early", 64'(ready), 0);
    @(negedge clk); check("rst0_ready_rise", 64'(ready), 1);

    // T1: single burst, partial last-word strobe.
    clear_log();
    send_desc(32'h100, 16'd4, 8'h0F, acc);
    wait_cpl(1);
    check("t1_nar", 64'(q_araddr.size()), 1);
    if (q_araddr.size() >= 1) begin
      check("t1_araddr", 64'(q_araddr[0]), 64'(BASE + 32'h100));
      check("t1_arlen", 64'(q_arlen[0]), 3);
    end
    check("t1_ar_latency", 64'(first_ar_cyc), 64'(acc + 1));
    check("t1_arsize", 64'(arsize), 3);
    check("t1_arburst", 64'(arburst), 1);
    check("t1_arid", 64'(arid), 0);
    check_pkt("t1", 32'h100, 4, 8'h0F);

    // T2: 190 words split by the maximum burst size.
    clear_log();
    send_desc(32'h0, 16'd190, 8'h00, acc);
    wait_cpl(1);
    check("t2_nar", 64'(q_araddr.size()), 3);
    if (q_araddr.size() == 3) begin
      check("t2_araddr0", 64'(q_araddr[0]), 64'(BASE + 32'h000));
      check("t2_arlen0", 64'(q_arlen[0]), 63);
      check("t2_araddr1", 64'(q_araddr[1]), 64'(BASE + 32'h200));
      check("t2_arlen1", 64'(q_arlen[1]), 63);
      check("t2_araddr2", 64'(q_araddr[2]), 64'(BASE + 32'h400));
      check("t2_arlen2", 64'(q_arlen[2]), 61);
    end
    check_pkt("t2", 32'h0, 190, 8'h00);

    // T3: 4 KB boundary split.
    clear_log();
    send_desc(32'hFF0, 16'd8, 8'h01, acc);
    wait_cpl(1);
    check("t3_nar", 64'(q_araddr.size()), 2);
    if (q_araddr.size() == 2) begin
      check("t3_araddr0", 64'(q_araddr[0]), 64'(BASE + 32'hFF0));
      check("t3_arlen0", 64'(q_arlen[0]), 1);
      check("t3_araddr1", 64'(q_araddr[1]), 64'(BASE + 32'h1000));
      check("t3_arlen1", 64'(q_arlen[1]), 5);
    end
    check_pkt("t3", 32'hFF0, 8, 8'h01);

    // T4: tready toggling, arready delayed by 3 cycles.
    clear_log();
    tready_toggle = 1; ar_delay = 3;
    send_desc(32'h2000, 16'd20, 8'h00, acc);
    wait_cpl(1);
    check("t4_nar", 64'(q_araddr.size()), 1);
    if (q_araddr.size() == 1) check("t4_arlen", 64'(q_arlen[0]), 19);
    check("t4_ar_wait", 64'(first_arhs_cyc - first_ar_cyc), 3);
    check("t4_ar_stable", 64'(ar_viol), 0);
    check("t4_rready_full", 64'(rr_viol), 0);
    check_pkt("t4", 32'h2000, 20, 8'h00);
    tready_toggle = 0; ar_delay = 0;

    // T5: error response on beat 2, then a zero-length descriptor.
    clear_log();
    err_beat = 1;
    send_desc(32'h300, 16'd4, 8'h00, acc);
    wait_cpl(1);
    check("t5_nerr", 64'(n_err), 1);
    check_pkt("t5", 32'h300, 4, 8'h00);
    err_beat = -1;
    clear_log();
    send_desc(32'h380, 16'd0, 8'h00, acc);
    wait_cpl(1);
    check("t5z_ncpl", 64'(n_cpl), 1);
    check("t5z_cpl_timing", 64'(cpl_cyc), 64'(acc + 2));
    check("t5z_nar", 64'(q_araddr.size()), 0);
    check("t5z_nbeats", 64'(q_data.size()), 0);
    check("t5z_nerr", 64'(n_err), 0);

    // T6: reset during a 64-word burst, then a fresh 2-word packet.
    clear_log();
    send_desc(32'h4000, 16'd64, 8'h00, acc);
    i = 0;
    while (q_data.size() < 10 && i < 500) begin @(posedge clk); i++; end
    check("t6_progress", 64'(q_data.size() >= 10), 1);
    @(posedge clk); #3 rst = 1;
    #1 check_reset_outputs("t6_rst");
    n_last_part = 0;
    foreach (q_last[k]) if (q_last[k]) n_last_part++;
    check("t6_partial_tlast", 64'(n_last_part), 0);
    check("t6_partial_ncpl", 64'(n_cpl), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); check_reset_outputs("t6_rst_hold");
    @(posedge clk); #2 rst = 0;
    @(negedge clk); check("t6_ready_early", 64'(ready), 0);
    @(negedge clk); check("t6_ready_rise", 64'(ready), 1);
    clear_log();
    send_desc(32'h500, 16'd2, 8'h3C, acc);
    wait_cpl(1);
    check("t6_nar", 64'(q_araddr.size()), 1);
    if (q_araddr.size() == 1) begin
      check("t6_araddr", 64'(q_araddr[0]), 64'(BASE + 32'h500));
      check("t6_arlen", 64'(q_arlen[0]), 1);
    end
    check_pkt("t6", 32'h500, 2, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
